// File: rtl/led_rom_sequencer_if.sv
// ROM read port between led_rom_sequencer (master) and the pattern ROM (slave).
// Latency: none, the ROM answers combinationally in the same cycle.
// Backpressure: none; the reader owns the address, the ROM always answers.
interface led_rom_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] addrRd;
    logic [15:0]       dataRd;

    modport master (output addrRd, input  dataRd);
    modport slave  (input  addrRd, output dataRd);
endinterface

// File: rtl/led_rom_sequencer.sv
// Fetches {pattern, hold} words from the LED ROM and plays them on the LEDs (LEDSEQ_LOOP_EN: loop on end marker).
// Latency: one FETCH cycle per word, then hold*TICK_DIV HOLD cycles; all outputs registered.
// Backpressure: none; en=0 drops back to IDLE on the next edge, overriding any tick or advance.
module led_rom_sequencer #(
    parameter int TICK_DIV = 50000,
    parameter int ADDR_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    led_rom_sequencer_if.master        rom,
    output logic [7:0]                 leds,
    output logic                       step,
    output logic                       done
);
    localparam int               PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    PONE      = PW'(1);
    localparam logic [ADDR_W-1:0] AONE     = ADDR_W'(1);
    localparam bit               DIV1      = (TICK_DIV == 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [PW-1:0]     presc;
    logic [7:0]        hold_cnt;
    logic              tick;

    assign rom.addrRd = addr_q;
    assign tick       = (presc == TICK_LAST);

    // step is registered, so it is raised one edge early: it must be visible
    // during the last HOLD cycle, before addrRd moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            leds     <= 8'h00;
            step     <= 1'b0;
            done     <= 1'b0;
            presc    <= '0;
            hold_cnt <= 8'd0;
        end else begin
            step <= 1'b0;
            if (state != IDLE && !en) begin
                state    <= IDLE;
                addr_q   <= '0;
                leds     <= 8'h00;
                done     <= 1'b0;
                presc    <= '0;
                hold_cnt <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (en) begin
                            state <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (rom.dataRd[7:0] != 8'd0) begin
                            leds     <= rom.dataRd[15:8];
                            hold_cnt <= rom.dataRd[7:0];
                            presc    <= '0;
                            state    <= HOLD;
                            step     <= DIV1 && (rom.dataRd[7:0] == 8'd1);
                        end else begin
`ifdef LEDSEQ_LOOP_EN
                            // Wrap pulse lands in the FETCH of address 0.
                            addr_q <= '0;
                            step   <= 1'b1;
`else
                            state  <= HALT;
                            done   <= 1'b1;
`endif
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            presc    <= '0;
                            hold_cnt <= hold_cnt - 8'd1;
                            if (hold_cnt == 8'd1) begin
                                addr_q <= addr_q + AONE;
                                state  <= FETCH;
                            end else begin
                                step <= DIV1 && (hold_cnt == 8'd2);
                            end
                        end else begin
                            presc <= presc + PONE;
                            step  <= ((presc + PONE) == TICK_LAST) && (hold_cnt == 8'd1);
                        end
                    end
                    HALT: begin
                        done <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_rom_sequencer.sv
// Directed bench for led_rom_sequencer at TICK_DIV=4 against a three-word ROM stub.
module tb_led_rom_sequencer;
    localparam int TICK_DIV = 4;
    localparam int ADDR_W   = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic [7:0] leds;
    logic       step;
    logic       done;
    logic       all_same = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int steps       = 0;

    led_rom_sequencer_if #(.ADDR_W(ADDR_W)) rom ();

    always_comb begin
        rom.dataRd = 16'h0101;
        if (!all_same) begin
            case (rom.addrRd)
                8'h00:   rom.dataRd = 16'hA002;
                8'h01:   rom.dataRd = 16'h5001;
                8'h02:   rom.dataRd = 16'h0000;
                default: rom.dataRd = 16'h0101;
            endcase
        end
    end

    led_rom_sequencer #(.TICK_DIV(TICK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .rom   (rom),
        .leds  (leds),
        .step  (step),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic [7:0] a, input logic [7:0] l,
                                         input logic s, input logic d);
        return {a, l, 7'd0, s, 7'd0, d};
    endfunction

    // Hand-derived outputs k edges after en rises from IDLE, one ROM pass.
    function automatic logic [31:0] exp_pass(input int k);
        if (k == 1)       return pack(8'h00, 8'h00, 1'b0, 1'b0);
        else if (k <= 9)  return pack(8'h00, 8'hA0, k == 9, 1'b0);
        else if (k == 10) return pack(8'h01, 8'hA0, 1'b0, 1'b0);
        else if (k <= 14) return pack(8'h01, 8'h50, k == 14, 1'b0);
        else              return pack(8'h02, 8'h50, 1'b0, 1'b0);
    endfunction

    function automatic logic [31:0] exp_seq(input int k);
        int j;
`ifdef LEDSEQ_LOOP_EN
        j = ((k - 1) % 15) + 1;
        if (k > 15 && j == 1) return pack(8'h00, 8'h50, 1'b1, 1'b0);
        return exp_pass(j);
`else
        j = k;
        if (j >= 16) return pack(8'h02, 8'h50, 1'b0, 1'b1);
        return exp_pass(j);
`endif
    endfunction

    function automatic logic [31:0] obs();
        return pack(rom.addrRd, leds, step, done);
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        // Power-up reset with en low.
        #1 rst_n = 1'b0;
        #2 chk("reset_async", obs(), pack(8'h00, 8'h00, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", obs(), pack(8'h00, 8'h00, 1'b0, 1'b0));
        end

        // Full run from address 0.
        en = 1'b1;
`ifdef LEDSEQ_LOOP_EN
        for (int k = 1; k <= 46; k++) begin
`else
        for (int k = 1; k <= 24; k++) begin
`endif
            @(negedge clk);
            chk("run", obs(), exp_seq(k));
        end

        // Drop en during the third HOLD cycle of address 0.
        en = 1'b0;
        @(negedge clk);
        chk("stop", obs(), pack(8'h00, 8'h00, 1'b0, 1'b0));
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("pre_drop", obs(), exp_seq(k));
        end
        en = 1'b0;
        @(negedge clk);
        chk("drop", obs(), pack(8'h00, 8'h00, 1'b0, 1'b0));
        en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk("restart", obs(), exp_seq(k));
        end

        // Asynchronous reset mid-HOLD of address 1, released with en high.
        #2 rst_n = 1'b0;
        #1 chk("mid_rst", obs(), pack(8'h00, 8'h00, 1'b0, 1'b0));
        @(negedge clk);
        chk("in_rst", obs(), pack(8'h00, 8'h00, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_fetch", obs(), pack(8'h00, 8'h00, 1'b0, 1'b0));
        @(negedge clk);
        chk("rel_hold", obs(), pack(8'h00, 8'hA0, 1'b0, 1'b0));

        // Uniform 0x0101 ROM: 5-cycle address sweep with wrap, no halt.
        en = 1'b0;
        @(negedge clk);
        all_same = 1'b1;
        en = 1'b1;
        for (int k = 1; k <= 1281; k++) begin
            @(negedge clk);
            if (step) steps++;
            if ((k - 1) % 5 == 0)
                chk("sweep_addr", 32'(rom.addrRd), 32'(((k - 1) / 5) % 256));
        end
        chk("sweep_steps", 32'(steps), 32'd256);
        chk("sweep_out", obs(), pack(8'h00, 8'h01, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
